// File: rtl/wb_path.sv
// wb_path: write-back path from the execute stage into the general register file.
//   The execute result triple {wd, wreg, wdata} passes through the ex/mem and
//   mem/wb registers and is then committed to the register array. Two
//   combinational read ports serve decode. Each port returns the newest
//   in-flight value, checked in this order: ex inputs, ex/mem, mem/wb, array.
// Ports:
//   clk, rst (async, active-low)
//   ex_wd/ex_wreg/ex_wdata  execute result triple
//   stall                   holds both stages and blocks the array write
//   flush                   clears the ex/mem entry
//   re1/raddr1/rdata1, re2/raddr2/rdata2   decode read ports
//   wb_wreg/wb_wd/wb_wdata  commit strobe and the mem/wb contents
module wb_path #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              stall,
  input  logic              flush,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              wb_wreg,
  output logic [ADDR_W-1:0] wb_wd,
  output logic [DATA_W-1:0] wb_wdata
);

  logic [ADDR_W-1:0] s1_wd_q, s1_wd_d, s2_wd_q;
  logic              s1_wreg_q, s1_wreg_d, s2_wreg_q;
  logic [DATA_W-1:0] s1_wdata_q, s1_wdata_d, s2_wdata_q;
  logic [DATA_W-1:0] regs_q [NREG];

  // A flush clears ex/mem even when the pipe is stalled.
  always_comb begin
    s1_wd_d    = s1_wd_q;
    s1_wreg_d  = s1_wreg_q;
    s1_wdata_d = s1_wdata_q;
    if (flush) begin
      s1_wd_d    = '0;
      s1_wreg_d  = 1'b0;
      s1_wdata_d = '0;
    end else if (!stall) begin
      s1_wd_d    = ex_wd;
      s1_wreg_d  = ex_wreg;
      s1_wdata_d = ex_wdata;
    end
  end

  assign wb_wreg  = s2_wreg_q && !stall && (s2_wd_q != '0);
  assign wb_wd    = s2_wd_q;
  assign wb_wdata = s2_wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_wd_q    <= '0;
      s1_wreg_q  <= 1'b0;
      s1_wdata_q <= '0;
      s2_wd_q    <= '0;
      s2_wreg_q  <= 1'b0;
      s2_wdata_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      s1_wd_q    <= s1_wd_d;
      s1_wreg_q  <= s1_wreg_d;
      s1_wdata_q <= s1_wdata_d;
      if (!stall) begin
        s2_wd_q    <= s1_wd_q;
        s2_wreg_q  <= s1_wreg_q;
        s2_wdata_q <= s1_wdata_q;
      end
      if (wb_wreg) regs_q[s2_wd_q] <= s2_wdata_q;
    end
  end

  // Address 0 never forwards, so matching on a zero address is excluded up
  // front. Gating with rst keeps the ex forward from leaking out during reset.
  function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] v;
    v = '0;
    if (rst && re && (ra != '0)) begin
      if (ex_wreg && ex_wd == ra)          v = ex_wdata;
      else if (s1_wreg_q && s1_wd_q == ra) v = s1_wdata_q;
      else if (s2_wreg_q && s2_wd_q == ra) v = s2_wdata_q;
      else                                 v = regs_q[ra];
    end
    return v;
  endfunction

  assign rdata1 = read_port(re1, raddr1);
  assign rdata2 = read_port(re2, raddr2);

endmodule
